bin2bcd_seq: RTL and testbench

Sequential double-dabble converter that turns the CPU's 16-bit binary register value into packed BCD digits for the seven-segment display driver. It sits between the CPU register output and the display driver, runs on the 100 MHz board clock, and processes one binary bit per cycle. A start/busy/done handshake controls each conversion. The last completed result stays stable on the output until the next conversion finishes.

---
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 tb/tb_bin2bcd_seq.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to packed BCD converter
module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock100Mhz,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      binIn,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcdOut
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [WIDTH-1:0] bin_q, bin_nxt;
  logic [BW-1:0]    bcd_q, bcd_nxt;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;
  logic [BW-1:0]    out_q, out_nxt;

  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_shift;
  logic [WIDTH-1:0] bin_shift;
  logic             last_iter;

  // Add-3 adjust on every digit of 5 or more, all digits in parallel, ahead of the shift
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // One iteration of the {bcd, bin} left shift; the binary MSB feeds the units digit
  assign bcd_shift = {bcd_adj[BW-2:0], bin_q[WIDTH-1]};
  assign bin_shift = {bin_q[WIDTH-2:0], 1'b0};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Next-state and datapath updates; done is a single-cycle pulse so it defaults low
  always_comb begin
    state_nxt = state;
    bin_nxt   = bin_q;
    bcd_nxt   = bcd_q;
    cnt_nxt   = cnt_q;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    out_nxt   = out_q;
    case (state)
      IDLE: begin
        if (start) begin
          bin_nxt   = binIn;
          bcd_nxt   = '0;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bin_nxt = bin_shift;
        bcd_nxt = bcd_shift;
        cnt_nxt = cnt_q + CW'(1);
        if (last_iter) begin
          out_nxt   = bcd_shift;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and register bank; reset abandons any in-flight conversion and clears the result
  always_ff @(posedge clock100Mhz or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      state  <= state_nxt;
      bin_q  <= bin_nxt;
      bcd_q  <= bcd_nxt;
      cnt_q  <= cnt_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      out_q  <= out_nxt;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign bcdOut = out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - directed self-checking bench for bin2bcd_seq
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;

  int total;
  int bad;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clock100Mhz (clk),
    .reset       (rst_n),
    .start       (start),
    .binIn       (bin_in),
    .busy        (busy),
    .done        (done),
    .bcdOut      (bcd_out)
  );

  // 100 MHz board clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(input int limit, output int cyc, output bit seen);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    start  = 1'b0;
    bin_in = 16'd0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 20'h0) begin
      bad++;
      $display("FAIL reset_async got busy=%b done=%b bcd=%h exp 0 0 00000", busy, done, bcd_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 20'h0) begin
        bad++;
        $display("FAIL reset_hold got busy=%b done=%b bcd=%h exp 0 0 00000", busy, done, bcd_out);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release_idle got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_convert(input logic [15:0] v, input logic [19:0] exp);
    int cyc;
    bit seen;
    @(negedge clk);
    bin_in = v;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL convert_busy v=%0d got=%b exp=1", v, busy);
    end
    wait_done(40, cyc, seen);
    total++;
    if (!seen || cyc != 16) begin
      bad++;
      $display("FAIL convert_latency v=%0d got seen=%0d cyc=%0d exp seen=1 cyc=16", v, seen, cyc);
    end
    total++;
    if (bcd_out !== exp) begin
      bad++;
      $display("FAIL convert_value v=%0d got=%h exp=%h", v, bcd_out, exp);
    end
  endtask

  task automatic test_handshake();
    int busy_cnt;
    busy_cnt = 0;
    @(negedge clk);
    bin_in = 16'd9999;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int k = 0; k < 40 && done !== 1'b1; k++) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
    end
    total++;
    if (done !== 1'b1 || busy_cnt != 16) begin
      bad++;
      $display("FAIL handshake_busy_len got done=%b busy_cycles=%0d exp done=1 busy_cycles=16", done, busy_cnt);
    end
    total++;
    if (busy !== 1'b0 || bcd_out !== 20'h09999) begin
      bad++;
      $display("FAIL handshake_done_cycle got busy=%b bcd=%h exp busy=0 bcd=09999", busy, bcd_out);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++;
      $display("FAIL handshake_done_pulse got done=%b exp=0", done);
    end
    for (int k = 0; k < 4; k++) @(negedge clk);
    total++;
    if (bcd_out !== 20'h09999 || done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL handshake_hold got bcd=%h done=%b busy=%b exp 09999 0 0", bcd_out, done, busy);
    end
  endtask

  task automatic test_ignored_start();
    int cyc;
    bit seen;
    int extra_done;
    int extra_busy;
    extra_done = 0;
    extra_busy = 0;
    @(negedge clk);
    bin_in = 16'd100;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bin_in = 16'd500;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    wait_done(40, cyc, seen);
    total++;
    if (!seen || bcd_out !== 20'h00100) begin
      bad++;
      $display("FAIL ignored_value got seen=%0d bcd=%h exp seen=1 bcd=00100", seen, bcd_out);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
      if (busy === 1'b1) extra_busy++;
    end
    total++;
    if (extra_done != 0 || extra_busy != 0 || bcd_out !== 20'h00100) begin
      bad++;
      $display("FAIL ignored_no_queue got dones=%0d busy_cycles=%0d bcd=%h exp 0 0 00100", extra_done, extra_busy, bcd_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit seen;
    @(negedge clk);
    bin_in = 16'd42;
    start  = 1'b1;
    wait_done(40, cyc, seen);
    total++;
    if (!seen || cyc != 17 || bcd_out !== 20'h00042) begin
      bad++;
      $display("FAIL b2b_first got seen=%0d cyc=%0d bcd=%h exp 1 17 00042", seen, cyc, bcd_out);
    end
    bin_in = 16'd7;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b1 || bcd_out !== 20'h00042) begin
      bad++;
      $display("FAIL b2b_accept got done=%b busy=%b bcd=%h exp 0 1 00042", done, busy, bcd_out);
    end
    wait_done(40, cyc, seen);
    start = 1'b0;
    total++;
    if (!seen || (cyc + 1) != 17 || bcd_out !== 20'h00007) begin
      bad++;
      $display("FAIL b2b_second got seen=%0d gap=%0d bcd=%h exp 1 17 00007", seen, cyc + 1, bcd_out);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_stop got busy=%b done=%b exp 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    int bad_out;
    dones   = 0;
    bad_out = 0;
    @(negedge clk);
    bin_in = 16'hFFFF;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int k = 0; k < 8; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || bcd_out !== 20'h0) begin
      bad++;
      $display("FAIL reset_mid_async got busy=%b done=%b bcd=%h exp 0 0 00000", busy, done, bcd_out);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (bcd_out !== 20'h0 || busy !== 1'b0) bad_out++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (bcd_out !== 20'h0 || busy !== 1'b0) bad_out++;
    end
    total++;
    if (dones != 0 || bad_out != 0) begin
      bad++;
      $display("FAIL reset_mid_abandon got dones=%0d nonzero_cycles=%0d exp 0 0", dones, bad_out);
    end
    test_convert(16'd1, 20'h00001);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_convert(16'd0, 20'h00000);
    test_convert(16'hFFFF, 20'h65535);
    test_convert(16'd1234, 20'h01234);
    test_handshake();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
